// File: rtl/mem_access_stage.sv
// Memory-access stage of the IITB-RISC pipeline: single loads/stores over a req/ready
// handshake and LM/SM sequencing one register per beat, state advancing on the falling edge.
module mem_access_stage #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_Validity_EX_MEM,
  input  logic [1:0]    in_op,
  input  logic          in_multi_load,
  input  logic [7:0]    in_mask,
  input  logic [DW-1:0] in_ALU_Result,
  input  logic [DW-1:0] in_Store_Data,
  input  logic [2:0]    in_RDest,
  input  logic          in_W_reg,
  input  logic [15:0]   in_pc,
  input  logic          in_stop,
  input  logic          in_BPR,
  output logic [2:0]    out_rf_addr,
  input  logic [DW-1:0] in_rf_data,
  output logic          out_mem_req,
  output logic          out_mem_we,
  output logic [AW-1:0] out_mem_addr,
  output logic [DW-1:0] out_mem_wdata,
  input  logic          in_mem_ready,
  input  logic [DW-1:0] in_mem_rdata,
  output logic [DW-1:0] out_Result,
  output logic [2:0]    out_RDest,
  output logic          out_W_reg,
  output logic [15:0]   out_pc,
  output logic          out_stop,
  output logic          out_BPR,
  output logic          out_Validity_MEM_WB,
  output logic          out_stall_MEM
);

  typedef enum logic [1:0] {IDLE, WAIT, MULTI} state_t;

  state_t        state, state_d;
  logic [7:0]    mask_q, mask_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          multi_load_q, multi_load_d;
  logic [2:0]    idx;
  logic          last_beat;
  logic          mem_op;

  // Scan from the top so the lowest set bit is the one left in idx.
  always_comb begin
    idx = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (mask_q[i-1]) idx = 3'(i - 1);
    end
  end

  assign last_beat = (mask_q & (mask_q - 8'd1)) == '0;
  assign mem_op    = (state == WAIT) ||
                     (state == IDLE && in_Validity_EX_MEM && (in_op == 2'b01 || in_op == 2'b10));

  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      mask_q       <= '0;
      addr_q       <= '0;
      multi_load_q <= 1'b0;
    end else begin
      state        <= state_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      multi_load_q <= multi_load_d;
    end
  end

  always_comb begin
    state_d             = state;
    mask_d              = mask_q;
    addr_d              = addr_q;
    multi_load_d        = multi_load_q;
    out_rf_addr         = '0;
    out_mem_req         = 1'b0;
    out_mem_we          = 1'b0;
    out_mem_addr        = '0;
    out_mem_wdata       = '0;
    out_Result          = '0;
    out_RDest           = '0;
    out_W_reg           = 1'b0;
    out_pc              = '0;
    out_stop            = 1'b0;
    out_BPR             = 1'b0;
    out_Validity_MEM_WB = 1'b0;
    out_stall_MEM       = 1'b0;
    case (state)
      IDLE, WAIT: begin
        if (mem_op) begin
          // WAIT relies on upstream being held, so the request is rebuilt from the inputs.
          out_mem_req   = 1'b1;
          out_mem_we    = (in_op == 2'b10);
          out_mem_addr  = AW'(in_ALU_Result);
          out_mem_wdata = in_Store_Data;
          if (in_mem_ready) begin
            out_Validity_MEM_WB = 1'b1;
            out_Result          = (in_op == 2'b10) ? in_ALU_Result : in_mem_rdata;
            out_RDest           = in_RDest;
            out_W_reg           = (in_op == 2'b01) && in_W_reg;
            out_pc              = in_pc;
            out_stop            = in_stop;
            out_BPR             = in_BPR;
            state_d             = IDLE;
          end else begin
            out_stall_MEM = 1'b1;
            state_d       = WAIT;
          end
        end else if (in_Validity_EX_MEM) begin
          if (in_op == 2'b11 && in_mask != '0) begin
            out_stall_MEM = 1'b1;
            mask_d        = in_mask;
            addr_d        = AW'(in_ALU_Result);
            multi_load_d  = in_multi_load;
            state_d       = MULTI;
          end else begin
            out_Validity_MEM_WB = 1'b1;
            out_Result          = in_ALU_Result;
            out_RDest           = in_RDest;
            out_W_reg           = (in_op == 2'b00) && in_W_reg;
            out_pc              = in_pc;
            out_stop            = in_stop;
            out_BPR             = in_BPR;
          end
        end
      end
      MULTI: begin
        out_mem_req   = 1'b1;
        out_mem_we    = !multi_load_q;
        out_mem_addr  = addr_q;
        out_rf_addr   = idx;
        out_mem_wdata = in_rf_data;
        out_Result    = in_mem_rdata;
        out_RDest     = idx;
        out_stall_MEM = 1'b1;
        if (in_mem_ready) begin
          mask_d              = mask_q & ~(8'd1 << idx);
          addr_d              = addr_q + AW'(1);
          out_Validity_MEM_WB = multi_load_q || last_beat;
          out_W_reg           = multi_load_q;
          out_stop            = last_beat && in_stop;
          if (multi_load_q || last_beat) begin
            out_pc  = in_pc;
            out_BPR = in_BPR;
          end
          if (last_beat) begin
            out_stall_MEM = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!resetn) begin
      out_rf_addr         = '0;
      out_mem_req         = 1'b0;
      out_mem_we          = 1'b0;
      out_mem_addr        = '0;
      out_mem_wdata       = '0;
      out_Result          = '0;
      out_RDest           = '0;
      out_W_reg           = 1'b0;
      out_pc              = '0;
      out_stop            = 1'b0;
      out_BPR             = 1'b0;
      out_Validity_MEM_WB = 1'b0;
      out_stall_MEM       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: table of single-cycle vectors, directed multi-cycle
// sequences and randomized instructions checked against a transaction-level model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_Validity_EX_MEM;
  logic [1:0]  in_op;
  logic        in_multi_load;
  logic [7:0]  in_mask;
  logic [15:0] in_ALU_Result, in_Store_Data;
  logic [2:0]  in_RDest;
  logic        in_W_reg;
  logic [15:0] in_pc;
  logic        in_stop, in_BPR;
  logic [2:0]  out_rf_addr;
  logic [15:0] in_rf_data;
  logic        out_mem_req, out_mem_we;
  logic [15:0] out_mem_addr, out_mem_wdata;
  logic        in_mem_ready;
  logic [15:0] in_mem_rdata;
  logic [15:0] out_Result;
  logic [2:0]  out_RDest;
  logic        out_W_reg;
  logic [15:0] out_pc;
  logic        out_stop, out_BPR, out_Validity_MEM_WB, out_stall_MEM;

  logic [15:0] regs [8];
  assign in_rf_data = regs[out_rf_addr];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.AW(16), .DW(16)) dut (
    .clk(clk), .resetn(resetn),
    .in_Validity_EX_MEM(in_Validity_EX_MEM), .in_op(in_op), .in_multi_load(in_multi_load),
    .in_mask(in_mask), .in_ALU_Result(in_ALU_Result), .in_Store_Data(in_Store_Data),
    .in_RDest(in_RDest), .in_W_reg(in_W_reg), .in_pc(in_pc), .in_stop(in_stop), .in_BPR(in_BPR),
    .out_rf_addr(out_rf_addr), .in_rf_data(in_rf_data),
    .out_mem_req(out_mem_req), .out_mem_we(out_mem_we), .out_mem_addr(out_mem_addr),
    .out_mem_wdata(out_mem_wdata), .in_mem_ready(in_mem_ready), .in_mem_rdata(in_mem_rdata),
    .out_Result(out_Result), .out_RDest(out_RDest), .out_W_reg(out_W_reg), .out_pc(out_pc),
    .out_stop(out_stop), .out_BPR(out_BPR), .out_Validity_MEM_WB(out_Validity_MEM_WB),
    .out_stall_MEM(out_stall_MEM)
  );

  // Field order: inputs v..rdata, then expected e_v..e_bpr.
  typedef struct packed {
    logic v; logic [1:0] op; logic [7:0] mask; logic [15:0] alu; logic [15:0] sd;
    logic [2:0] rd; logic w; logic stop; logic bpr; logic rdy; logic [15:0] rdata;
    logic e_v; logic [15:0] e_res; logic chk_res; logic [2:0] e_rd; logic e_w;
    logic e_req; logic e_we; logic [15:0] e_addr; logic [15:0] e_wd;
    logic e_stall; logic e_stop; logic e_bpr;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Plays one instruction held on the inputs until it completes; waits<0 means random ready.
  task automatic run_instr(input int waits, output int pulses);
    logic [15:0] base, a;
    int remaining, k, n;
    bit last, rdy, ml;
    pulses = 0;
    ml = in_multi_load;
    if (!in_Validity_EX_MEM || in_op == 2'b00 || (in_op == 2'b11 && in_mask == 8'h00)) begin
      in_mem_ready = 1'($urandom_range(0, 1));
      in_mem_rdata = 16'($urandom);
      #2;
      pulses += int'(out_Validity_MEM_WB);
      chk("pass_req", out_mem_req, 0);
      chk("pass_stall", out_stall_MEM, 0);
      chk("pass_valid", out_Validity_MEM_WB, in_Validity_EX_MEM);
      chk("pass_wreg", out_W_reg, in_Validity_EX_MEM && in_op == 2'b00 && in_W_reg);
      if (in_Validity_EX_MEM) begin
        if (in_op == 2'b00) begin
          chk("pass_result", out_Result, in_ALU_Result);
          chk("pass_rdest", out_RDest, in_RDest);
        end
        chk("pass_pc", out_pc, in_pc);
        chk("pass_stop", out_stop, in_stop);
        chk("pass_bpr", out_BPR, in_BPR);
      end else begin
        chk("inv_rdest", out_RDest, 0);
        chk("inv_stop", out_stop, 0);
        chk("inv_bpr", out_BPR, 0);
      end
      step();
    end else if (in_op != 2'b11) begin
      n = 0;
      do begin
        rdy = (waits < 0) ? (n >= 5 || $urandom_range(0, 2) != 0) : (n >= waits);
        in_mem_ready = rdy;
        in_mem_rdata = 16'($urandom);
        #2;
        pulses += int'(out_Validity_MEM_WB);
        chk("mem_req", out_mem_req, 1);
        chk("mem_addr", out_mem_addr, in_ALU_Result);
        chk("mem_we", out_mem_we, in_op == 2'b10);
        chk("mem_wdata", out_mem_wdata, in_Store_Data);
        chk("mem_valid", out_Validity_MEM_WB, rdy);
        chk("mem_stall", out_stall_MEM, !rdy);
        if (rdy) begin
          chk("mem_wreg", out_W_reg, in_op == 2'b01 && in_W_reg);
          chk("mem_rdest", out_RDest, in_RDest);
          chk("mem_pc", out_pc, in_pc);
          if (in_op == 2'b01) chk("load_result", out_Result, in_mem_rdata);
        end else begin
          chk("mem_wreg_wait", out_W_reg, 0);
        end
        step();
        n++;
      end while (!rdy);
    end else begin
      in_mem_ready = 1'($urandom_range(0, 1));
      #2;
      chk("cap_req", out_mem_req, 0);
      chk("cap_stall", out_stall_MEM, 1);
      chk("cap_valid", out_Validity_MEM_WB, 0);
      step();
      base = in_ALU_Result;
      remaining = $countones(in_mask);
      k = 0;
      for (int i = 0; i < 8; i++) begin
        if (in_mask[i]) begin
          remaining--;
          last = (remaining == 0);
          a = base + 16'(k);
          n = 0;
          do begin
            rdy = (waits < 0) ? (n >= 5 || $urandom_range(0, 2) != 0) : (n >= waits);
            in_mem_ready = rdy;
            in_mem_rdata = 16'($urandom);
            #2;
            pulses += int'(out_Validity_MEM_WB);
            chk("beat_req", out_mem_req, 1);
            chk("beat_addr", out_mem_addr, a);
            chk("beat_we", out_mem_we, !ml);
            if (!ml) begin
              chk("sm_rf_addr", out_rf_addr, i);
              chk("sm_wdata", out_mem_wdata, regs[i]);
            end
            if (rdy) begin
              chk("beat_valid", out_Validity_MEM_WB, ml || last);
              chk("beat_stall", out_stall_MEM, !last);
              chk("beat_stop", out_stop, last ? in_stop : 1'b0);
              if (ml) begin
                chk("lm_result", out_Result, in_mem_rdata);
                chk("lm_rdest", out_RDest, i);
                chk("lm_wreg", out_W_reg, 1);
              end else if (last) begin
                chk("sm_wreg", out_W_reg, 0);
              end
              if (ml || last) begin
                chk("beat_pc", out_pc, in_pc);
                chk("beat_bpr", out_BPR, in_BPR);
              end
            end else begin
              chk("beat_valid_wait", out_Validity_MEM_WB, 0);
              chk("beat_stall_wait", out_stall_MEM, 1);
            end
            step();
            n++;
          end while (!rdy);
          k++;
        end
      end
    end
  endtask

  task automatic set_instr(input logic v, input logic [1:0] op, input logic ml, input logic [7:0] mask,
                           input logic [15:0] alu, input logic [15:0] sd, input logic [2:0] rd,
                           input logic w, input logic [15:0] pc, input logic stop, input logic bpr);
    in_Validity_EX_MEM = v; in_op = op; in_multi_load = ml; in_mask = mask;
    in_ALU_Result = alu; in_Store_Data = sd; in_RDest = rd; in_W_reg = w;
    in_pc = pc; in_stop = stop; in_BPR = bpr;
  endtask

  initial begin
    int p;
    tbl[0] = '{1, 2'b00, 8'h00, 16'h1234, 16'h0000, 3'd5, 1, 0, 0, 0, 16'h0000,
               1, 16'h1234, 1, 3'd5, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
    tbl[1] = '{1, 2'b01, 8'h00, 16'h0022, 16'h0000, 3'd3, 1, 0, 1, 1, 16'h5A5A,
               1, 16'h5A5A, 1, 3'd3, 1, 1, 0, 16'h0022, 16'h0000, 0, 0, 1};
    tbl[2] = '{1, 2'b10, 8'h00, 16'h0030, 16'hCAFE, 3'd2, 1, 1, 0, 1, 16'h1111,
               1, 16'h0000, 0, 3'd2, 0, 1, 1, 16'h0030, 16'hCAFE, 0, 1, 0};
    tbl[3] = '{0, 2'b01, 8'h00, 16'h0040, 16'h9999, 3'd6, 1, 1, 1, 1, 16'h2222,
               0, 16'h0000, 0, 3'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
    tbl[4] = '{1, 2'b11, 8'h00, 16'h0050, 16'h0000, 3'd0, 1, 0, 1, 0, 16'h0000,
               1, 16'h0000, 0, 3'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1};
    tbl[5] = '{1, 2'b00, 8'h00, 16'hFFFF, 16'h0000, 3'd7, 0, 1, 1, 1, 16'h3333,
               1, 16'hFFFF, 1, 3'd7, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1};
    tbl[6] = '{0, 2'b11, 8'hFF, 16'h0060, 16'h0000, 3'd1, 1, 0, 0, 0, 16'h0000,
               0, 16'h0000, 0, 3'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};

    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
    resetn = 1'b0;
    set_instr(1, 2'b01, 0, 8'h00, 16'h0040, 16'h0, 3'd1, 1, 16'h0100, 1, 1);
    in_mem_ready = 1'b1; in_mem_rdata = 16'hAAAA;
    #2;
    chk("rst_req", out_mem_req, 0);
    chk("rst_stall", out_stall_MEM, 0);
    chk("rst_valid", out_Validity_MEM_WB, 0);
    chk("rst_result", out_Result, 0);
    step();
    resetn = 1'b1;
    in_Validity_EX_MEM = 1'b0;
    step();

    foreach (tbl[i]) begin
      set_instr(tbl[i].v, tbl[i].op, 1'b0, tbl[i].mask, tbl[i].alu, tbl[i].sd, tbl[i].rd,
                tbl[i].w, 16'h0200 + 16'(i), tbl[i].stop, tbl[i].bpr);
      in_mem_ready = tbl[i].rdy; in_mem_rdata = tbl[i].rdata;
      #2;
      chk("tbl_valid", out_Validity_MEM_WB, tbl[i].e_v);
      if (tbl[i].chk_res) chk("tbl_result", out_Result, tbl[i].e_res);
      chk("tbl_rdest", out_RDest, tbl[i].e_rd);
      chk("tbl_wreg", out_W_reg, tbl[i].e_w);
      chk("tbl_req", out_mem_req, tbl[i].e_req);
      if (tbl[i].e_req) begin
        chk("tbl_we", out_mem_we, tbl[i].e_we);
        chk("tbl_addr", out_mem_addr, tbl[i].e_addr);
        chk("tbl_wdata", out_mem_wdata, tbl[i].e_wd);
      end
      chk("tbl_stall", out_stall_MEM, tbl[i].e_stall);
      chk("tbl_stop", out_stop, tbl[i].e_stop);
      chk("tbl_bpr", out_BPR, tbl[i].e_bpr);
      step();
    end

    set_instr(1, 2'b01, 0, 8'h00, 16'h0040, 16'h0, 3'd2, 1, 16'h0300, 0, 0);
    run_instr(2, p);
    chk("load_wait_pulses", p, 1);

    set_instr(1, 2'b11, 1, 8'b1001_0010, 16'h00FE, 16'h0, 3'd0, 1, 16'h0310, 0, 1);
    run_instr(0, p);
    chk("lm_pulses", p, 3);

    set_instr(1, 2'b11, 0, 8'h81, 16'hFFFF, 16'h0, 3'd0, 1, 16'h0320, 1, 0);
    run_instr(0, p);
    chk("sm_pulses", p, 1);

    set_instr(1, 2'b11, 1, 8'b0000_0110, 16'h0010, 16'h0, 3'd0, 1, 16'h0330, 0, 0);
    in_mem_ready = 1'b1;
    step();
    #2;
    chk("lmr_beat1_addr", out_mem_addr, 16'h0010);
    step();
    resetn = 1'b0;
    #2;
    chk("lmr_req", out_mem_req, 0);
    chk("lmr_stall", out_stall_MEM, 0);
    chk("lmr_valid", out_Validity_MEM_WB, 0);
    chk("lmr_wreg", out_W_reg, 0);
    chk("lmr_addr", out_mem_addr, 0);
    chk("lmr_rdest", out_RDest, 0);
    step();
    resetn = 1'b1;
    set_instr(1, 2'b00, 0, 8'h00, 16'h4321, 16'h0, 3'd6, 1, 16'h0340, 0, 0);
    run_instr(0, p);
    chk("post_rst_pulses", p, 1);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
      set_instr($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom), 16'($urandom),
                3'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      run_instr(-1, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
